mips_alu_issue: RTL and testbench
=================================

Name: mips_alu_issue

Overview:
- ID/EX issue stage that drives the 32-bit MIPS ALU's operand/control interface (A, B, Cin, ALUctr, OverflowCheck).
- Decodes a MIPS32 instruction plus register-file read values into the registered ALU control code and operands, with destination/write-enable sideband.
- Single registered pipeline slot with valid/ready handshake, stall and flush; sits between the register-file read and the ALU.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- OPR_W, 5, ALU control code width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction/operands present
- in_ready  out  1  stage can accept this cycle
- instr  in  32  instruction word
- rs_val  in  32  register-file value of rs
- rt_val  in  32  register-file value of rt
- flush  in  1  kill held and incoming instruction
- out_valid  out  1  registered slot holds an instruction
- out_ready  in  1  ALU/EX consumer accepts
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_opr  out  5  ALU control code
- alu_cin  out  1  carry in, always 0
- alu_ovf_chk  out  1  OverflowCheck
- wr_en  out  1  result writes back to the register file
- wr_addr  out  5  destination register
- illegal  out  1  undecodable instruction

Behaviour:
- Reset (async, rst_n=0): out_valid=0, and alu_a, alu_b, alu_opr, alu_cin, alu_ovf_chk, wr_en, wr_addr, illegal all 0. Reset mid-transfer drops the held instruction; no output pulses on release.
- in_ready = !out_valid || out_ready (combinational). Load = in_valid && in_ready && !flush.
- flush: out_valid <= 0 next edge, and the same-cycle input is discarded. Flush has priority over load.
- Hold: when out_valid && !out_ready, every output is held stable.
- Latency: exactly 1 cycle, input accepted at edge N appears at outputs after N.
- ALU codes: ADD=1, SUB=2, AND=3, OR=4, XOR=5, NOR=6, SLT=7, SLTU=8, SLL=9, SRL=10, SRA=11, BEQ=12, BNE=13, BGEZ=14, BGTZ=15, BLEZ=16, BLTZ=17, LUI=18.
- R-type (op 0), selected by funct:
  - add 0x20 / addu 0x21: ADD. A=rs, B=rt, ovf=1 for add, 0 for addu.
  - sub 0x22 / subu 0x23: SUB. A=rs, B=rt, ovf=1 for sub, 0 for subu.
  - and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A, sltu 0x2B: A=rs, B=rt.
  - sll 0x00, srl 0x02, sra 0x03: A=rt, B={27'b0, shamt}.
  - sllv 0x04, srlv 0x06, srav 0x07: A=rt, B=rs.
  - R-type destination is rd.
- I-type, A=rs:
  - addi 0x08 (ovf=1) / addiu 0x09: ADD with sign-extended imm.
  - slti 0x0A / sltiu 0x0B: SLT / SLTU with sign-extended imm.
  - andi 0x0C, ori 0x0D, xori 0x0E: zero-extended imm.
  - lui 0x0F: LUI with B=zero-extended imm.
  - I-type destination is rt.
- Branches: A=rs, B=rt, wr_en=0.
  - beq 0x04, bne 0x05, blez 0x06, bgtz 0x07.
  - op 0x01 with rt=0 is BLTZ, rt=1 is BGEZ.
- wr_en = 1 for ALU-result instructions with destination ≠ 0. The word 0x00000000 (nop) therefore gives wr_en=0.
- ovf_chk is 0 for every instruction not listed with ovf=1.
- Illegal opcode or funct, or regimm rt∉{0,1}:
  - illegal=1, alu_opr=0, wr_en=0, ovf=0.
  - The instruction still travels through the handshake.

Test Plan:
- 0x00221820 (add $3,$1,$2), rs=5, rt=7 -> next cycle out_valid=1, opr=1, a=5, b=7, ovf=1, wr_en=1, wr_addr=3.
- 0x2022FFFF (addi $2,$1,-1) -> opr=1, b=0xFFFFFFFF, wr_addr=2. Then 0x3C051234 (lui) -> opr=18, b=0x00001234, wr_addr=5. Then 0x00031100 (sll $2,$3,4), rt=0x80 -> opr=9, a=0x80, b=4.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged. Raising out_ready gives one transfer per cycle with no loss or duplication.
- Flush: hold an instruction, assert flush together with a new in_valid -> out_valid=0 next cycle and the new instruction is dropped.
- Illegal and branches:
  - funct 0x3F -> illegal=1, opr=0, wr_en=0.
  - 0x04010001 (regimm rt=1) -> opr=14, wr_en=0.
  - 0x00000000 -> wr_en=0.
- Reset mid-stream: rst_n=0 asynchronously while out_valid=1 -> all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/mips_alu_issue_if.sv
// Handshake and operand bus between register-file read, the ALU issue stage and the ALU.
// master drives instructions in and consumes the ALU controls; slave is the issue stage.
interface mips_alu_issue_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OPR_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [XLEN-1:0]  rs_val;
  logic [XLEN-1:0]  rt_val;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  alu_a;
  logic [XLEN-1:0]  alu_b;
  logic [OPR_W-1:0] alu_opr;
  logic             alu_cin;
  logic             alu_ovf_chk;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic             illegal;

  modport master (
    output in_valid, instr, rs_val, rt_val, flush, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_opr, alu_cin, alu_ovf_chk,
           wr_en, wr_addr, illegal
  );

  modport slave (
    input  in_valid, instr, rs_val, rt_val, flush, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_opr, alu_cin, alu_ovf_chk,
           wr_en, wr_addr, illegal
  );
endinterface

// File: rtl/mips_alu_issue.sv
// ID/EX issue stage: decodes a MIPS32 instruction and register values into registered
// ALU operands and control code, with a single valid/ready slot, stall and flush.
module mips_alu_issue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OPR_W = 5
) (
  input logic             clk,
  input logic             rst_n,
  mips_alu_issue_if.slave bus
);

  localparam logic [OPR_W-1:0] OprAdd  = 5'd1;
  localparam logic [OPR_W-1:0] OprSub  = 5'd2;
  localparam logic [OPR_W-1:0] OprAnd  = 5'd3;
  localparam logic [OPR_W-1:0] OprOr   = 5'd4;
  localparam logic [OPR_W-1:0] OprXor  = 5'd5;
  localparam logic [OPR_W-1:0] OprNor  = 5'd6;
  localparam logic [OPR_W-1:0] OprSlt  = 5'd7;
  localparam logic [OPR_W-1:0] OprSltu = 5'd8;
  localparam logic [OPR_W-1:0] OprSll  = 5'd9;
  localparam logic [OPR_W-1:0] OprSrl  = 5'd10;
  localparam logic [OPR_W-1:0] OprSra  = 5'd11;
  localparam logic [OPR_W-1:0] OprBeq  = 5'd12;
  localparam logic [OPR_W-1:0] OprBne  = 5'd13;
  localparam logic [OPR_W-1:0] OprBgez = 5'd14;
  localparam logic [OPR_W-1:0] OprBgtz = 5'd15;
  localparam logic [OPR_W-1:0] OprBlez = 5'd16;
  localparam logic [OPR_W-1:0] OprBltz = 5'd17;
  localparam logic [OPR_W-1:0] OprLui  = 5'd18;

  logic [5:0]       w_op;
  logic [5:0]       w_fn;
  logic [4:0]       w_rt_addr;
  logic [4:0]       w_rd_addr;
  logic [4:0]       w_shamt;
  logic [15:0]      w_imm;
  logic [XLEN-1:0]  w_imm_sext;
  logic [XLEN-1:0]  w_imm_zext;

  assign w_op       = bus.instr[31:26];
  assign w_rt_addr  = bus.instr[20:16];
  assign w_rd_addr  = bus.instr[15:11];
  assign w_shamt    = bus.instr[10:6];
  assign w_fn       = bus.instr[5:0];
  assign w_imm      = bus.instr[15:0];
  assign w_imm_sext = {{(XLEN-16){w_imm[15]}}, w_imm};
  assign w_imm_zext = {{(XLEN-16){1'b0}}, w_imm};

  logic [OPR_W-1:0] w_opr;
  logic [XLEN-1:0]  w_a;
  logic [XLEN-1:0]  w_b;
  logic             w_ovf;
  logic             w_writes;
  logic [4:0]       w_dst;
  logic             w_ill;
  logic             w_wr_en;

  always_comb begin
    w_opr    = '0;
    w_a      = bus.rs_val;
    w_b      = bus.rt_val;
    w_ovf    = 1'b0;
    w_writes = 1'b0;
    w_dst    = w_rd_addr;
    w_ill    = 1'b0;
    unique case (w_op)
      6'h00: begin
        w_writes = 1'b1;
        unique case (w_fn)
          6'h20:   begin w_opr = OprAdd; w_ovf = 1'b1; end
          6'h21:   w_opr = OprAdd;
          6'h22:   begin w_opr = OprSub; w_ovf = 1'b1; end
          6'h23:   w_opr = OprSub;
          6'h24:   w_opr = OprAnd;
          6'h25:   w_opr = OprOr;
          6'h26:   w_opr = OprXor;
          6'h27:   w_opr = OprNor;
          6'h2A:   w_opr = OprSlt;
          6'h2B:   w_opr = OprSltu;
          6'h00, 6'h02, 6'h03: begin
            w_opr = (w_fn == 6'h00) ? OprSll : (w_fn == 6'h02) ? OprSrl : OprSra;
            w_a   = bus.rt_val;
            w_b   = {{(XLEN-5){1'b0}}, w_shamt};
          end
          6'h04, 6'h06, 6'h07: begin
            w_opr = (w_fn == 6'h04) ? OprSll : (w_fn == 6'h06) ? OprSrl : OprSra;
            w_a   = bus.rt_val;
            w_b   = bus.rs_val;
          end
          default: w_ill = 1'b1;
        endcase
      end
      6'h01: begin
        if (w_rt_addr == 5'd0)      w_opr = OprBltz;
        else if (w_rt_addr == 5'd1) w_opr = OprBgez;
        else                        w_ill = 1'b1;
      end
      6'h04: w_opr = OprBeq;
      6'h05: w_opr = OprBne;
      6'h06: w_opr = OprBlez;
      6'h07: w_opr = OprBgtz;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        w_writes = 1'b1;
        w_dst    = w_rt_addr;
        w_b      = w_imm_sext;
        unique case (w_op)
          6'h08:   begin w_opr = OprAdd; w_ovf = 1'b1; end
          6'h09:   w_opr = OprAdd;
          6'h0A:   w_opr = OprSlt;
          6'h0B:   w_opr = OprSltu;
          6'h0C:   begin w_opr = OprAnd; w_b = w_imm_zext; end
          6'h0D:   begin w_opr = OprOr;  w_b = w_imm_zext; end
          6'h0E:   begin w_opr = OprXor; w_b = w_imm_zext; end
          default: begin w_opr = OprLui; w_b = w_imm_zext; end
        endcase
      end
      default: w_ill = 1'b1;
    endcase
    // An undecodable word still travels the pipe but must not drive any ALU side effect.
    if (w_ill) begin
      w_opr    = '0;
      w_ovf    = 1'b0;
      w_writes = 1'b0;
    end
  end

  assign w_wr_en = w_writes && (w_dst != 5'd0);

  logic             r_valid;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [OPR_W-1:0] r_opr;
  logic             r_ovf;
  logic             r_wr_en;
  logic [4:0]       r_wr_addr;
  logic             r_ill;
  logic             w_in_ready;
  logic             w_load;

  assign w_in_ready = !r_valid || bus.out_ready;
  assign w_load     = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_opr     <= '0;
      r_ovf     <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_ill     <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid   <= 1'b1;
      r_a       <= w_a;
      r_b       <= w_b;
      r_opr     <= w_opr;
      r_ovf     <= w_ovf;
      r_wr_en   <= w_wr_en;
      r_wr_addr <= w_dst;
      r_ill     <= w_ill;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_valid;
  assign bus.alu_a       = r_a;
  assign bus.alu_b       = r_b;
  assign bus.alu_opr     = r_opr;
  assign bus.alu_cin     = 1'b0;
  assign bus.alu_ovf_chk = r_ovf;
  assign bus.wr_en       = r_wr_en;
  assign bus.wr_addr     = r_wr_addr;
  assign bus.illegal     = r_ill;

endmodule

// File: tb/tb_mips_alu_issue.sv
// Self-checking bench for mips_alu_issue: directed vector table, handshake corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_mips_alu_issue;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mips_alu_issue_if bus ();

  mips_alu_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  opr;
    logic [31:0] a;
    logic [31:0] b;
    logic        ovf;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic        ill;
    logic        dchk;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".opr"}, 32'(bus.alu_opr), 32'(e.opr));
    chk({tag, ".ovf"}, 32'(bus.alu_ovf_chk), 32'(e.ovf));
    chk({tag, ".wr_en"}, 32'(bus.wr_en), 32'(e.wr_en));
    chk({tag, ".illegal"}, 32'(bus.illegal), 32'(e.ill));
    chk({tag, ".cin"}, 32'(bus.alu_cin), 32'd0);
    if (!e.ill) begin
      chk({tag, ".a"}, bus.alu_a, e.a);
      chk({tag, ".b"}, bus.alu_b, e.b);
    end
    if (e.dchk) chk({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'(e.wr_addr));
  endtask

  // Reference decode: classify the word, then pick operands from the class.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs,
                                 input logic [31:0] rt);
    exp_t        e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] se;
    logic [31:0] ze;
    int          code;
    bit          writes;
    bit          ovf;
    op = ins[31:26];
    fn = ins[5:0];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    code = 0;
    writes = 0;
    ovf = 0;
    e.instr = ins; e.rs = rs; e.rt = rt;
    e.a = rs; e.b = rt; e.wr_addr = 0;
    if (op == 0) begin
      e.wr_addr = ins[15:11];
      writes = 1;
      case (fn)
        6'h20: begin code = 1; ovf = 1; end
        6'h21: code = 1;
        6'h22: begin code = 2; ovf = 1; end
        6'h23: code = 2;
        6'h24: code = 3;
        6'h25: code = 4;
        6'h26: code = 5;
        6'h27: code = 6;
        6'h2A: code = 7;
        6'h2B: code = 8;
        6'h00: begin code = 9;  e.a = rt; e.b = 32'(ins[10:6]); end
        6'h02: begin code = 10; e.a = rt; e.b = 32'(ins[10:6]); end
        6'h03: begin code = 11; e.a = rt; e.b = 32'(ins[10:6]); end
        6'h04: begin code = 9;  e.a = rt; e.b = rs; end
        6'h06: begin code = 10; e.a = rt; e.b = rs; end
        6'h07: begin code = 11; e.a = rt; e.b = rs; end
        default: code = 0;
      endcase
    end else if (op >= 6'h08 && op <= 6'h0F) begin
      e.wr_addr = ins[20:16];
      writes = 1;
      case (op)
        6'h08: begin code = 1; ovf = 1; e.b = se; end
        6'h09: begin code = 1; e.b = se; end
        6'h0A: begin code = 7; e.b = se; end
        6'h0B: begin code = 8; e.b = se; end
        6'h0C: begin code = 3; e.b = ze; end
        6'h0D: begin code = 4; e.b = ze; end
        6'h0E: begin code = 5; e.b = ze; end
        default: begin code = 18; e.b = ze; end
      endcase
    end else if (op == 6'h01) begin
      code = (ins[20:16] == 0) ? 17 : (ins[20:16] == 1) ? 14 : 0;
    end else if (op >= 6'h04 && op <= 6'h07) begin
      code = (op == 4) ? 12 : (op == 5) ? 13 : (op == 6) ? 16 : 15;
    end
    e.ill = (code == 0);
    e.opr = 5'(code);
    e.ovf = ovf && !e.ill;
    e.wr_en = writes && !e.ill && (e.wr_addr != 0);
    e.dchk = writes && !e.ill;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt, input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.rs_val    = rs;
    bus.rt_val    = rt;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  exp_t vec[$];
  exp_t q[$];

  function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] rs,
                              input logic [31:0] rt, input int opr, input logic [31:0] a,
                              input logic [31:0] b, input bit ovf, input bit wr,
                              input int addr, input bit ill, input bit dchk);
    exp_t e;
    e.instr = ins; e.rs = rs; e.rt = rt; e.opr = 5'(opr); e.a = a; e.b = b;
    e.ovf = ovf; e.wr_en = wr; e.wr_addr = 5'(addr); e.ill = ill; e.dchk = dchk;
    return e;
  endfunction

  initial begin
    exp_t e;
    exp_t held;
    total = 0;
    bad   = 0;
    // instr, rs, rt, opr, a, b, ovf, wr_en, wr_addr, illegal, check wr_addr
    vec.push_back(mk(32'h00221820, 5, 7, 1, 5, 7, 1, 1, 3, 0, 1));
    vec.push_back(mk(32'h2022FFFF, 10, 0, 1, 10, 32'hFFFFFFFF, 1, 1, 2, 0, 1));
    vec.push_back(mk(32'h3C051234, 0, 0, 18, 0, 32'h00001234, 0, 1, 5, 0, 1));
    vec.push_back(mk(32'h00031100, 0, 32'h80, 9, 32'h80, 4, 0, 1, 2, 0, 1));
    vec.push_back(mk(32'h0022183F, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0));
    vec.push_back(mk(32'h04010001, 32'h11, 32'h22, 14, 32'h11, 32'h22, 0, 0, 0, 0, 0));
    vec.push_back(mk(32'h00000000, 1, 2, 9, 2, 0, 0, 0, 0, 0, 1));
    vec.push_back(mk(32'h00221822, 9, 4, 2, 9, 4, 1, 1, 3, 0, 1));
    vec.push_back(mk(32'h00221823, 9, 4, 2, 9, 4, 0, 1, 3, 0, 1));
    vec.push_back(mk(32'h28A3FFFE, 6, 0, 7, 6, 32'hFFFFFFFE, 0, 1, 3, 0, 1));
    vec.push_back(mk(32'h30A48000, 6, 0, 3, 6, 32'h00008000, 0, 1, 4, 0, 1));
    vec.push_back(mk(32'h10220003, 3, 4, 12, 3, 4, 0, 0, 0, 0, 0));
    vec.push_back(mk(32'h00A41007, 8, 32'hF0000000, 11, 32'hF0000000, 8, 0, 1, 2, 0, 1));
    vec.push_back(mk(32'h04020000, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0));
    vec.push_back(mk(32'h20200005, 1, 2, 1, 1, 5, 1, 0, 0, 0, 1));
    vec.push_back(mk(32'hFC000000, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0));
    vec.push_back(mk(32'h00221827, 1, 2, 6, 1, 2, 0, 1, 3, 0, 1));
    vec.push_back(mk(32'h04200000, 7, 8, 17, 7, 8, 0, 0, 0, 0, 0));

    drive(0, 0, 0, 0, 1, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.valid", 32'(bus.out_valid), 0);
    chk("reset.opr", 32'(bus.alu_opr), 0);
    chk("reset.a", bus.alu_a, 0);
    chk("reset.wr_en", 32'(bus.wr_en), 0);
    rst_n = 1'b1;

    // Back-to-back table vectors, one per cycle with the consumer always ready.
    foreach (vec[i]) begin
      @(negedge clk);
      if (i > 0) cmp($sformatf("vec%0d", i - 1), vec[i - 1]);
      drive(1, vec[i].instr, vec[i].rs, vec[i].rt, 1, 0);
    end
    @(negedge clk);
    cmp($sformatf("vec%0d", vec.size() - 1), vec[vec.size() - 1]);
    drive(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("drain.valid", 32'(bus.out_valid), 0);

    // Backpressure: hold add while sub waits at the input.
    drive(1, vec[0].instr, vec[0].rs, vec[0].rt, 0, 0);
    @(negedge clk);
    drive(1, vec[7].instr, vec[7].rs, vec[7].rt, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d.in_ready", k), 32'(bus.in_ready), 0);
      cmp($sformatf("bp%0d", k), vec[0]);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp.in_ready_up", 32'(bus.in_ready), 1);
    @(negedge clk);
    cmp("bp.next", vec[7]);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp.nodup", 32'(bus.out_valid), 0);

    // Flush while holding, with a new instruction offered the same cycle.
    drive(1, vec[2].instr, 0, 0, 0, 0);
    @(negedge clk);
    cmp("fl.held", vec[2]);
    drive(1, vec[0].instr, vec[0].rs, vec[0].rt, 1, 1);
    @(negedge clk);
    chk("fl.valid", 32'(bus.out_valid), 0);
    drive(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("fl.dropped", 32'(bus.out_valid), 0);

    // Asynchronous reset between edges while an instruction is held.
    drive(1, vec[0].instr, vec[0].rs, vec[0].rt, 0, 0);
    @(negedge clk);
    chk("rst.pre_valid", 32'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.valid", 32'(bus.out_valid), 0);
    chk("rst.a", bus.alu_a, 0);
    chk("rst.b", bus.alu_b, 0);
    chk("rst.opr", 32'(bus.alu_opr), 0);
    chk("rst.ovf", 32'(bus.alu_ovf_chk), 0);
    chk("rst.wr_en", 32'(bus.wr_en), 0);
    chk("rst.wr_addr", 32'(bus.wr_addr), 0);
    chk("rst.illegal", 32'(bus.illegal), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.release", 32'(bus.out_valid), 0);

    // Random traffic: scoreboard queue holds what the slot should contain.
    q.delete();
    for (int c = 0; c < 400; c++) begin
      logic [31:0] ins;
      logic [31:0] rs;
      logic [31:0] rt;
      logic        v;
      logic        ordy;
      logic        fl;
      bit          rdy_exp;
      @(negedge clk);
      if (q.size() != 0) cmp($sformatf("rnd%0d", c), q[0]);
      else chk($sformatf("rnd%0d.valid", c), 32'(bus.out_valid), 0);
      ins = $urandom;
      case ($urandom_range(0, 5))
        0, 1: ins[31:26] = 6'h00;
        2:    ins[31:26] = 6'(8 + $urandom_range(0, 7));
        3:    begin ins[31:26] = 6'h01; ins[20:16] = 5'($urandom_range(0, 2)); end
        4:    ins[31:26] = 6'(4 + $urandom_range(0, 3));
        default: ;
      endcase
      if (ins[31:26] == 0 && $urandom_range(0, 1) == 1) ins[5:0] = 6'h20 + 6'($urandom_range(0, 11));
      rs   = $urandom;
      rt   = $urandom;
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 9) == 0);
      drive(v, ins, rs, rt, ordy, fl);
      rdy_exp = (q.size() == 0) || ordy;
      #1 chk($sformatf("rnd%0d.in_ready", c), 32'(bus.in_ready), 32'(rdy_exp));
      if (fl) q.delete();
      else begin
        if (q.size() != 0 && ordy) void'(q.pop_front());
        if (v && rdy_exp) begin
          e = model(ins, rs, rt);
          q.push_back(e);
        end
      end
    end
    held = vec[0];
    if (held.instr != 0) ;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
